// File: rtl/attn_score_seq.sv
// Attention score sequencer: loads a query, streams keys into an external MAC, emits one saturated score per key.
// Score valid 3 cycles after the last key element; in_rdy low while draining/emitting, score held until score_rdy.
module attn_score_seq #(
  parameter int DW     = 8,
  parameter int N_FEAT = 4,
  parameter int N_KEYS = 4,
  parameter int ACC_W  = 17,
  parameter int SHIFT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             in_data,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic                      mac_clr,
  output logic                      mac_en,
  output logic [DW-1:0]             mac_op_a,
  output logic [DW-1:0]             mac_op_b,
  input  logic [ACC_W-1:0]          mac_acc,
  output logic [DW-1:0]             score_data,
  output logic                      score_vld,
  input  logic                      score_rdy,
  output logic [$clog2(N_KEYS)-1:0] key_idx,
  output logic                      frame_done
);

  localparam int FW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int KW = $clog2(N_KEYS);
  localparam logic [FW-1:0] FEAT_LAST = FW'(N_FEAT - 1);
  localparam logic [KW-1:0] KEY_LAST  = KW'(N_KEYS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    LOAD_Q,
    LOAD_K,
    DRAIN_A,
    DRAIN_B,
    EMIT
  } state_t;

  state_t                  state, state_nxt;
  logic [FW-1:0]           feat_cnt, feat_nxt;
  logic [KW-1:0]           key_nxt;
  logic [DW-1:0]           q [N_FEAT];
  logic                    q_we;
  logic                    in_xfer;
  logic                    score_xfer;
  logic                    in_rdy_nxt;
  logic                    clr_nxt;
  logic                    en_nxt;
  logic                    vld_nxt;
  logic                    done_nxt;
  logic [DW-1:0]           op_a_nxt;
  logic [DW-1:0]           op_b_nxt;
  logic [DW-1:0]           score_nxt;
  logic signed [ACC_W-1:0] acc_sh;
  logic [DW-1:0]           acc_sat;

  // in_rdy is only ever high in LOAD_Q/LOAD_K, so a transfer implies one of those states
  assign in_xfer    = in_vld & in_rdy;
  assign score_xfer = score_vld & score_rdy;
  assign acc_sh     = $signed(mac_acc) >>> SHIFT;

  always_comb begin
    acc_sat = acc_sh[DW-1:0];
    if (acc_sh > SAT_MAX) begin
      acc_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (acc_sh < SAT_MIN) begin
      acc_sat = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_comb begin
    state_nxt = state;
    feat_nxt  = feat_cnt;
    key_nxt   = key_idx;
    q_we      = 1'b0;
    op_a_nxt  = mac_op_a;
    op_b_nxt  = mac_op_b;
    score_nxt = score_data;
    clr_nxt   = 1'b0;
    en_nxt    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      LOAD_Q: begin
        if (in_xfer) begin
          q_we = 1'b1;
          if (feat_cnt == FEAT_LAST) begin
            feat_nxt  = '0;
            state_nxt = LOAD_K;
            clr_nxt   = 1'b1;
          end else begin
            feat_nxt = feat_cnt + FW'(1);
          end
        end
      end
      LOAD_K: begin
        if (in_xfer) begin
          op_a_nxt = q[feat_cnt];
          op_b_nxt = in_data;
          en_nxt   = 1'b1;
          if (feat_cnt == FEAT_LAST) begin
            feat_nxt  = '0;
            state_nxt = DRAIN_A;
          end else begin
            feat_nxt = feat_cnt + FW'(1);
          end
        end
      end
      DRAIN_A: state_nxt = DRAIN_B;
      DRAIN_B: begin
        // mac_acc now includes the final product issued in DRAIN_A
        score_nxt = acc_sat;
        state_nxt = EMIT;
      end
      EMIT: begin
        if (score_xfer) begin
          if (key_idx == KEY_LAST) begin
            key_nxt   = '0;
            state_nxt = LOAD_Q;
            done_nxt  = 1'b1;
          end else begin
            key_nxt   = key_idx + KW'(1);
            state_nxt = LOAD_K;
            clr_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = LOAD_Q;
    endcase
    in_rdy_nxt = (state_nxt == LOAD_Q) || (state_nxt == LOAD_K);
    vld_nxt    = (state_nxt == EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_Q;
      feat_cnt   <= '0;
      key_idx    <= '0;
      in_rdy     <= 1'b0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      mac_op_a   <= '0;
      mac_op_b   <= '0;
      score_data <= '0;
      score_vld  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) begin
        q[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      feat_cnt   <= feat_nxt;
      key_idx    <= key_nxt;
      in_rdy     <= in_rdy_nxt;
      mac_clr    <= clr_nxt;
      mac_en     <= en_nxt;
      mac_op_a   <= op_a_nxt;
      mac_op_b   <= op_b_nxt;
      score_data <= score_nxt;
      score_vld  <= vld_nxt;
      frame_done <= done_nxt;
      if (q_we) begin
        q[feat_cnt] <= in_data;
      end
    end
  end

endmodule
